// File: rtl/phase_sequencer.sv
// Modulo-64 frame phase counter with first/last slot strobes
// for sequencing the shared equalizer filter datapath.
module phase_sequencer #(
   parameter int unsigned COUNT_WIDTH = 6,
   parameter int unsigned RESET_VALUE = 63
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_enable,
   output logic [COUNT_WIDTH-1:0] current_count,
   output logic                   phase_0,
   output logic                   phase_63
);

   localparam logic [COUNT_WIDTH-1:0] CntRst  = COUNT_WIDTH'(RESET_VALUE);
   localparam logic [COUNT_WIDTH-1:0] CntOne  = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CntLast = '1;

   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   // Natural wrap of the adder gives the 63 -> 0 rollover.
   always_comb begin
      count_d = count_q;
      if (clk_enable) begin
         count_d = count_q + CntOne;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= CntRst;
      end else begin
         count_q <= count_d;
      end
   end

   // Strobes are unregistered so a re-enable raises them in the same cycle.
   always_comb begin
      current_count = count_q;
      phase_0       = clk_enable && (count_q == '0);
      phase_63      = clk_enable && (count_q == CntLast);
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus pushes expected
// count/strobes, a negedge monitor pops and compares.
module tb_phase_sequencer;

   typedef struct packed {
      logic [5:0] cnt;
      logic       p0;
      logic       p63;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       clk_enable;
   logic [5:0] current_count;
   logic       phase_0;
   logic       phase_63;

   exp_t q[$];
   int   total;
   int   bad;

   phase_sequencer #(
      .COUNT_WIDTH(6),
      .RESET_VALUE(63)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_enable   (clk_enable),
      .current_count(current_count),
      .phase_0      (phase_0),
      .phase_63     (phase_63)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 ns after a rising edge; the expected value is what
   // the outputs must show at the following falling edge.
   task automatic step(input logic r, input logic e, input int c);
      exp_t x;
      @(posedge clk);
      #1;
      rst        = r;
      clk_enable = e;
      x.cnt = 6'(c);
      x.p0  = e && (c == 0);
      x.p63 = e && (c == 63);
      q.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            x = q.pop_front();
            total++;
            if ({current_count, phase_0, phase_63} !== x) begin
               bad++;
               $display("FAIL slot_chk t=%0t got cnt=%0d p0=%b p63=%b want cnt=%0d p0=%b p63=%b",
                        $time, current_count, phase_0, phase_63,
                        x.cnt, x.p0, x.p63);
            end
         end
      end
   end

   initial begin : stim
      int budget;
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      clk_enable = 1'b1;

      // reset held with enable high
      repeat (10) step(1'b1, 1'b1, 63);

      // release: first edge still sees rst, then 0..63,0..35
      step(1'b0, 1'b1, 63);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, i % 64);
      step(1'b0, 1'b1, 36);

      // mid-frame reset: 63 must appear before the next edge
      repeat (6) step(1'b1, 1'b1, 63);
      step(1'b0, 1'b1, 63);
      for (int i = 0; i < 200; i++) step(1'b0, 1'b1, i % 64);

      // run to 19, then freeze at 20 for five cycles
      for (int c = 8; c < 20; c++) step(1'b0, 1'b1, c);
      repeat (5) step(1'b0, 1'b0, 20);
      step(1'b0, 1'b1, 20);
      step(1'b0, 1'b1, 21);

      // gating at the frame boundaries
      for (int c = 22; c < 63; c++) step(1'b0, 1'b1, c);
      step(1'b0, 1'b0, 63);
      step(1'b0, 1'b0, 63);
      step(1'b0, 1'b1, 63);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1);

      budget = 20;
      while (q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
